ddr_tx_frame_ctrl: RTL and testbench
====================================

Name: ddr_tx_frame_ctrl

Overview:
- Frame sequencer that feeds the dp/dn inputs of a dual-edge output flip-flop.
- Accepts 2*DATA_WIDTH-bit words on a valid/ready stream. Emits fixed-length frames: preamble word, FRAME_LEN payload words, then an idle gap.
- Each cycle it presents the upper half of the selected word on dp (rising-edge half) and the lower half on dn (falling-edge half).
- Sits between the sample/packetiser stream and the DDR pad register on the host or ADC link.

Parameters:
- DATA_WIDTH, 8: width of each half-word; dp/dn width.
- FRAME_LEN, 16: payload words per frame; must be >= 1.
- GAP_CYCLES, 2: idle cycles (oe=0) after each frame; 0 allowed.
- PREAMBLE, 16'hA55A: 2*DATA_WIDTH-bit word emitted first in every frame.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: frame request pulse or level.
- s_data, input, 2*DATA_WIDTH: payload word.
- s_valid, input, 1: s_data valid.
- s_ready, output, 1: controller accepts a word this cycle.
- dp, output, DATA_WIDTH: to dual FF rising-edge input; registered.
- dn, output, DATA_WIDTH: to dual FF falling-edge input; registered.
- oe, output, 1: pad output enable; registered; aligned with dp/dn.
- busy, output, 1: state != IDLE.
- frame_done, output, 1: one-cycle pulse at end of frame.
- underrun, output, 1: sticky flag, set when payload was missing during a frame.

Behaviour:
- Reset: async, forces state IDLE. dp=0, dn=0, oe=0, s_ready=0, frame_done=0, underrun=0, word counter=0, start_pending=0.

FSM states: IDLE, PRE, DATA, [PAR], GAP.
- IDLE: start=1 -> PRE next cycle.
- PRE: one cycle, selects PREAMBLE -> DATA.
- DATA: FRAME_LEN cycles, counter 0..FRAME_LEN-1. After the last word -> PAR if compiled in, else -> GAP (or IDLE/PRE when GAP_CYCLES=0, by the rule below).
- GAP: GAP_CYCLES cycles, selects 0 with oe=0. On exit -> PRE if start_pending or start, else IDLE.

Start handling:
- start asserted in any state other than IDLE sets start_pending. It is cleared on entry to PRE.
- A level-held start therefore produces back-to-back frames separated by GAP_CYCLES.

Stream handshake:
- s_ready is combinational and equals (state==DATA). Transfer occurs when s_valid && s_ready.
- Underrun: in DATA with s_valid=0, the selected word is all-zeros, oe stays 1, the counter still advances (frame length is fixed), and underrun is set.
- underrun clears only when a new frame enters PRE, or on reset.

Output timing and latency:
- The selected word/oe is registered into dp, dn, oe on the next rising edge. Output lags the state by exactly 1 cycle.
- dp = word[2*DATA_WIDTH-1:DATA_WIDTH]; dn = word[DATA_WIDTH-1:0].
- A word accepted in cycle N appears on dp/dn in cycle N+1. The dual FF adds its own half-cycle stages on top of that.
- In IDLE and GAP: oe=0, dp=dn=0.

frame_done:
- Registered pulse, asserted the cycle the final frame word (last payload word, or parity word if compiled in) appears on dp/dn.

Counter:
- Width $clog2(FRAME_LEN), minimum 1 bit. Resets to 0 on entry to DATA. No wrap inside a frame.

Reset mid-frame:
- Aborts immediately. Outputs return to reset values asynchronously.
- No partial frame is resumed; start_pending is lost.

Optional Feature:
- Macro: DDR_TX_FRAME_PARITY_EN.
- Defined:
  - A PAR state (1 cycle) follows DATA.
  - It emits the bitwise XOR of all FRAME_LEN emitted payload words, including zero fills, with oe=1.
  - s_ready=0 in PAR. The parity accumulator clears in PRE.
  - Frame length = FRAME_LEN+2 words.
- Undefined: no PAR state, no accumulator. Frame length = FRAME_LEN+1 words.

Test Plan (DATA_WIDTH=8, FRAME_LEN=4, GAP_CYCLES=2, PREAMBLE=16'hA55A):
1. Reset, start pulse, s_valid=1 with words 1111,2222,3333,4444 -> dp/dn sequence A5/5A, 11/11, 22/22, 33/33, 44/44. oe=1 for 5 cycles, starting 2 cycles after start. frame_done coincides with 44/44. Then oe=0 for 2 cycles, busy drops, underrun=0.
2. Same as 1, but s_valid=0 during the 2nd payload cycle -> output sequence 1111, 0000, 2222, 3333. underrun=1 and held through IDLE; cleared at next PRE. 4th word (4444) not consumed.
3. start held at 1 -> frames repeat, exactly 2 oe=0 cycles between 44/44 and the next A5/5A. Repeat with GAP_CYCLES=0 -> A5/5A immediately follows 44/44.
4. start pulse during DATA of frame 1 -> second frame begins right after the gap. Pulse during IDLE only -> a single frame.
5. rst_n low during the 3rd payload word -> dp=dn=0, oe=0, s_ready=0 with no clock edge. After release with start=0 -> stays IDLE.
6. DDR_TX_FRAME_PARITY_EN defined, scenario 1 stimulus -> extra word 0x4444 (1111^2222^3333^4444) after 44/44. frame_done moves to the parity word. s_ready low during PAR.

Source files
------------

// File: rtl/ddr_tx_frame_ctrl.sv
// Frame sequencer feeding the dp/dn inputs of a dual-edge output flop: preamble, FRAME_LEN payload words, idle gap.
// Optional trailing parity word is compiled in with `define DDR_TX_FRAME_PARITY_EN.
module ddr_tx_frame_ctrl #(
  parameter int                        DATA_WIDTH = 8,
  parameter int                        FRAME_LEN  = 16,
  parameter int                        GAP_CYCLES = 2,
  parameter logic [2*DATA_WIDTH-1:0]   PREAMBLE   = 16'hA55A
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   dp,
  output logic [DATA_WIDTH-1:0]   dn,
  output logic                    oe,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
);

  localparam int WW       = 2 * DATA_WIDTH;
  localparam int CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pend_q, pend_d;
  logic            under_q, under_d;
  logic [DATA_WIDTH-1:0] dp_q, dn_q;
  logic            oe_q, oe_d;
  logic            done_q, done_d;
  logic [WW-1:0]   word_d;
  state_e          exit_state;
  state_e          end_state;
`ifdef DDR_TX_FRAME_PARITY_EN
  logic [WW-1:0]   par_q, par_d;
`endif

  // Where the sequencer goes once the gap is over (or straight after the frame when there is no gap).
  assign exit_state = (pend_q || start) ? S_PRE : S_IDLE;
  assign end_state  = (GAP_CYCLES > 0) ? S_GAP : exit_state;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    under_d = under_q;
    word_d  = '0;
    oe_d    = 1'b0;
    done_d  = 1'b0;
`ifdef DDR_TX_FRAME_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PRE;
      end

      S_PRE: begin
        word_d  = PREAMBLE;
        oe_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_DATA;
`ifdef DDR_TX_FRAME_PARITY_EN
        par_d   = '0;
`endif
      end

      S_DATA: begin
        // A missing word is replaced by zeros; the frame length never stretches.
        word_d = s_valid ? s_data : '0;
        oe_d   = 1'b1;
        if (!s_valid) under_d = 1'b1;
`ifdef DDR_TX_FRAME_PARITY_EN
        par_d  = par_q ^ word_d;
`endif
        if (cnt_q == CW'(FRAME_LEN - 1)) begin
`ifdef DDR_TX_FRAME_PARITY_EN
          state_d = S_PAR;
`else
          done_d  = 1'b1;
          state_d = end_state;
          gap_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PAR: begin
`ifdef DDR_TX_FRAME_PARITY_EN
        word_d  = par_q;
        oe_d    = 1'b1;
        done_d  = 1'b1;
`endif
        state_d = end_state;
        gap_d   = '0;
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = exit_state;
        else                        gap_d   = gap_q + GW'(1);
      end

      default: state_d = S_IDLE;
    endcase

    // A request seen while already busy is remembered until the next frame starts.
    if (start && state_q != S_IDLE) pend_d = 1'b1;
    if (state_d == S_PRE) begin
      pend_d  = 1'b0;
      under_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      under_q <= 1'b0;
      dp_q    <= '0;
      dn_q    <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef DDR_TX_FRAME_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      under_q <= under_d;
      dp_q    <= word_d[WW-1:DATA_WIDTH];
      dn_q    <= word_d[DATA_WIDTH-1:0];
      oe_q    <= oe_d;
      done_q  <= done_d;
`ifdef DDR_TX_FRAME_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign s_ready    = (state_q == S_DATA);
  assign busy       = (state_q != S_IDLE);
  assign dp         = dp_q;
  assign dn         = dn_q;
  assign oe         = oe_q;
  assign frame_done = done_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_ddr_tx_frame_ctrl.sv
// Directed bench for ddr_tx_frame_ctrl (FRAME_LEN=4, GAP_CYCLES=2, plus a GAP_CYCLES=0 instance).
// Expectations follow DDR_TX_FRAME_PARITY_EN when it is defined for the build.
module tb_ddr_tx_frame_ctrl;

  localparam logic [15:0] PRE = 16'hA55A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_g;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready, oe, busy, frame_done, underrun;
  logic [7:0]  dp, dn;
  logic        s_ready_g, oe_g, busy_g, frame_done_g, underrun_g;
  logic [7:0]  dp_g, dn_g;

  logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  int          wi;
  int          fd_count;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ddr_tx_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(4), .GAP_CYCLES(2), .PREAMBLE(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dp(dp), .dn(dn), .oe(oe), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  ddr_tx_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(4), .GAP_CYCLES(0), .PREAMBLE(PRE)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start_g), .s_data(16'h4444), .s_valid(1'b1),
    .s_ready(s_ready_g), .dp(dp_g), .dn(dn_g), .oe(oe_g), .busy(busy_g),
    .frame_done(frame_done_g), .underrun(underrun_g)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: note whether a word transfers, advance past the edge, then present the next word.
  task automatic tick();
    logic xfer;
    xfer = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (xfer) wi++;
    s_data = (wi < 4) ? words[wi] : 16'hDEAD;
    if (frame_done) fd_count++;
  endtask

  // Runs one frame from IDLE; payload slot 'drop' (or -1) sees s_valid=0.
  task automatic do_frame(input int drop, input string nm);
    logic [15:0] exp_w;
    logic [15:0] par;
    int          c;
    wi = 0; c = 0; par = '0;
    s_data = words[0]; s_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_pre_busy"}, busy, 1'b1);
    check({nm, "_pre_oe"}, oe, 1'b0);
    check({nm, "_pre_rdy"}, s_ready, 1'b0);
    check({nm, "_pre_under"}, underrun, 1'b0);
    tick();
    check({nm, "_preamble"}, {dp, dn}, PRE);
    check({nm, "_preamble_oe"}, oe, 1'b1);
    check({nm, "_data_rdy"}, s_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == drop) s_valid = 1'b0;
      tick();
      s_valid = 1'b1;
      exp_w = (k == drop) ? 16'h0000 : words[c];
      if (k != drop) c++;
      par ^= exp_w;
      check($sformatf("%s_word%0d", nm, k), {dp, dn}, exp_w);
      check($sformatf("%s_oe%0d", nm, k), oe, 1'b1);
      check($sformatf("%s_under%0d", nm, k), underrun, (drop >= 0 && k >= drop));
`ifdef DDR_TX_FRAME_PARITY_EN
      check($sformatf("%s_done%0d", nm, k), frame_done, 1'b0);
`else
      check($sformatf("%s_done%0d", nm, k), frame_done, k == 3);
`endif
    end
`ifdef DDR_TX_FRAME_PARITY_EN
    check({nm, "_par_rdy"}, s_ready, 1'b0);
    tick();
    check({nm, "_parity"}, {dp, dn}, par);
    check({nm, "_parity_oe"}, oe, 1'b1);
    check({nm, "_parity_done"}, frame_done, 1'b1);
`endif
    tick();
    check({nm, "_gap0_oe"}, oe, 1'b0);
    check({nm, "_gap0_data"}, {dp, dn}, 16'h0000);
    check({nm, "_gap0_done"}, frame_done, 1'b0);
    tick();
    check({nm, "_gap1_oe"}, oe, 1'b0);
    check({nm, "_idle_busy"}, busy, 1'b0);
    check({nm, "_underrun_end"}, underrun, drop >= 0);
    check({nm, "_consumed"}, wi, c);
  endtask

  initial begin
    int  zeros_a, zeros_g;
    bit  seen_a, seen_g, done_a, done_g;

    rst_n = 1'b0; start = 1'b0; start_g = 1'b0; s_valid = 1'b0;
    s_data = words[0]; wi = 0; fd_count = 0;
    #12;
    check("rst_dpdn", {dp, dn}, 16'h0000);
    check("rst_oe", oe, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_under", underrun, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", busy, 1'b0);

    // Clean frame, then one with a missing second payload word.
    do_frame(-1, "f1");
    do_frame(1, "f2");
    repeat (3) tick();
    check("under_held_idle", underrun, 1'b1);
    check("under_idle_busy", busy, 1'b0);
    do_frame(-1, "f3");

    // Level-held start: measure idle cycles between the end of one frame and the next preamble.
    start = 1'b1; start_g = 1'b1; s_valid = 1'b1; wi = 0;
    zeros_a = 0; zeros_g = 0; seen_a = 0; seen_g = 0; done_a = 0; done_g = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!done_a) begin
        if (seen_a) begin
          if (oe && {dp, dn} == PRE) begin
            check("held_gap2", zeros_a, 2);
            done_a = 1;
          end else if (!oe) zeros_a++;
        end
        if (frame_done) seen_a = 1;
      end
      if (!done_g) begin
        if (seen_g) begin
          if (oe_g && {dp_g, dn_g} == PRE) begin
            check("held_gap0", zeros_g, 0);
            done_g = 1;
          end else if (!oe_g) zeros_g++;
        end
        if (frame_done_g) seen_g = 1;
      end
    end
    check("held_gap2_seen", done_a, 1'b1);
    check("held_gap0_seen", done_g, 1'b1);
    start = 1'b0; start_g = 1'b0;
    repeat (25) tick();
    check("held_stop_busy", busy, 1'b0);
    check("held_stop_busy_g0", busy_g, 1'b0);

    // Start pulse during DATA queues exactly one more frame.
    fd_count = 0; wi = 0; s_data = words[0];
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pend_in_data", s_ready, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    check("pend_two_frames", fd_count, 2);
    check("pend_end_busy", busy, 1'b0);

    // Start pulse in IDLE only gives a single frame.
    fd_count = 0; wi = 0; s_data = words[0];
    start = 1'b1; tick(); start = 1'b0;
    repeat (30) tick();
    check("single_frame", fd_count, 1);

    // Reset during the third payload word, with a pending request that must be lost.
    wi = 0; s_data = words[0]; s_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    check("abort_pre_oe", oe, 1'b1);
    check("abort_pre_under", underrun, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_dpdn", {dp, dn}, 16'h0000);
    check("abort_oe", oe, 1'b0);
    check("abort_ready", s_ready, 1'b0);
    check("abort_under", underrun, 1'b0);
    #2;
    rst_n = 1'b1;
    s_valid = 1'b1;
    repeat (6) tick();
    check("abort_stays_idle", busy, 1'b0);
    check("abort_idle_oe", oe, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
